vga_pong_renderizador: RTL and testbench
========================================

Name: vga_pong_renderizador

Overview:
- Parametrised VGA timing generator and pong scene renderer, driven from the 50 MHz board clock.
- Produces H/V sync and RGB for two paddles, a ball and a court border.
- Paddle and ball coordinates are sampled once per frame into shadow registers, so the picture never tears mid-frame.
- Sits between the game logic (positions) and the VGA connector; fimQuadro paces game-logic updates.

Parameters:
DIV, 2, clock divider; pixel tick every DIV clocks (50 MHz/2 = 25 MHz).
H_ATIVO, 640, visible pixels per line.
H_FP, 16, horizontal front porch.
H_SYNC, 96, horizontal sync width.
H_BP, 48, horizontal back porch.
V_ATIVO, 480, visible lines.
V_FP, 10, vertical front porch.
V_SYNC, 2, vertical sync width.
V_BP, 33, vertical back porch.
COORD_W, 11, width of all coordinate inputs.
COR_W, 4, bits per colour channel.
PAL1_X, 5, left x of paddle 1.
PAL2_X, 605, left x of paddle 2.
PAL_L, 31, paddle width in pixels.
BOLA_T, 8, ball side length in pixels.
BORDA, 2, border thickness in pixels; 0 disables the border.

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
palete1YMaximo, palete1YMinimo  in  COORD_W  paddle 1 bottom/top line, inclusive
palete2YMaximo, palete2YMinimo  in  COORD_W  paddle 2 bottom/top line, inclusive
bolaX, bolaY  in  COORD_W  ball top-left corner
bolaVisivel  in  1  ball is drawn when 1
vermelho, verde, azul  out  COR_W  registered colour outputs
horizontalsincronizacao  out  1  H sync, active low
verticalsincronizacao  out  1  V sync, active low
videoAtivo  out  1  high while the emitted pixel is inside the visible area
fimQuadro  out  1  one-clock pulse at each frame boundary

Behaviour:
- Interface: single clock domain (clock). Reset is synchronous and active-high on the port named reset; it is sampled only on a rising clock edge.
- Totals: H_TOTAL = H_ATIVO+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ATIVO+V_FP+V_SYNC+V_BP (525).
- Divider: counter runs 0..DIV-1. tick is high for exactly one clock when counter == DIV-1. All other state advances only on tick.
- Counters hc 0..H_TOTAL-1 and vc 0..V_TOTAL-1:
  - hc wraps at H_TOTAL-1 and increments vc at the same tick.
  - vc wraps at V_TOTAL-1.
- Frame boundary: tick with hc == H_TOTAL-1 and vc == V_TOTAL-1. At that tick:
  - Shadow registers latch all seven position inputs and bolaVisivel.
  - fimQuadro is high for that one clock only.
  - Input changes at any other time have no effect until the next boundary.
- Outputs are registered on tick from the current hc/vc, so they lag the counters by one pixel (latency: 1 pixel = DIV clocks). All outputs hold between ticks.
- horizontalsincronizacao = 0 iff H_ATIVO+H_FP <= hc < H_ATIVO+H_FP+H_SYNC (656..751).
- verticalsincronizacao = 0 iff V_ATIVO+V_FP <= vc < V_ATIVO+V_FP+V_SYNC (490..491).
- videoAtivo = (hc < H_ATIVO) and (vc < V_ATIVO). Outside the visible area all colours are 0.
- Colour priority inside the visible area:
  1. Ball (all channels max): shadow bolaVisivel, bolaX <= hc < bolaX+BOLA_T, and bolaY <= vc < bolaY+BOLA_T.
  2. Paddle n (all channels max): PALn_X <= hc < PALn_X+PAL_L and Ymin <= vc <= Ymax. If Ymin > Ymax the paddle is not drawn.
  3. Border (verde max, others 0): hc < BORDA, hc >= H_ATIVO-BORDA, vc < BORDA, or vc >= V_ATIVO-BORDA.
  4. Otherwise black.
- Coordinate arithmetic is COORD_W+1 bits wide, so bolaX+BOLA_T cannot wrap. A ball partly off-screen is clipped; coordinates >= the active size draw nothing.
- Reset values:
  - Divider, hc and vc = 0.
  - Colours = 0; both syncs = 1; videoAtivo = 0; fimQuadro = 0.
  - Shadows: paddles min=1, max=0 (hidden); bolaVisivel = 0.
- Reset mid-frame restarts the timing at hc=vc=0 on the next clock. Inputs are not picked up until the first frame boundary after reset.

Test Plan:
- Reset release, run 2 frames -> H sync low 96 ticks per 800; V sync low for lines 490-491 per 525-line frame; fimQuadro period 2*800*525 = 840000 clocks.
- Paddle 1 Ymin=100, Ymax=160 held before a boundary -> white pixels at hc 5..35, vc 100..160 inclusive; pixels at vc 99 and vc 161 are black (or border colour where the border applies).
- Change palete1YMaximo mid-frame (vc=200) -> current frame unchanged; new extent visible from the next frame only.
- Ball at (636,470), visible, BOLA_T=8 -> clipped to hc 636..639, vc 470..477; no colour when videoAtivo=0. Ball over paddle 2 area -> ball colour wins.
- Ymin=300 > Ymax=200 -> paddle absent for the whole frame; border still green at hc 0..1.
- Assert reset at hc=400, vc=300 for 1 clock -> next clock: counters 0, syncs 1, colours 0; fimQuadro pulses first after 840000 clocks.

Source files
------------

// File: rtl/vga_pong_renderizador.sv
// vga_pong_renderizador: VGA raster timing and pong scene renderer.
// A pixel tick every DIV clocks walks an hc/vc raster. On each tick the sync,
// blanking and colour for the current raster position are registered, so
// outputs trail the counters by one pixel. Paddle and ball positions are
// captured only at the frame boundary, so a frame always shows one snapshot.
module vga_pong_renderizador #(
  parameter int DIV     = 2,
  parameter int H_ATIVO = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ATIVO = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int COORD_W = 11,
  parameter int COR_W   = 4,
  parameter int PAL1_X  = 5,
  parameter int PAL2_X  = 605,
  parameter int PAL_L   = 31,
  parameter int BOLA_T  = 8,
  parameter int BORDA   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] palete1YMaximo,
  input  logic [COORD_W-1:0] palete1YMinimo,
  input  logic [COORD_W-1:0] palete2YMaximo,
  input  logic [COORD_W-1:0] palete2YMinimo,
  input  logic [COORD_W-1:0] bolaX,
  input  logic [COORD_W-1:0] bolaY,
  input  logic               bolaVisivel,
  output logic [COR_W-1:0]   vermelho,
  output logic [COR_W-1:0]   verde,
  output logic [COR_W-1:0]   azul,
  output logic               horizontalsincronizacao,
  output logic               verticalsincronizacao,
  output logic               videoAtivo,
  output logic               fimQuadro
);

  localparam int H_TOTAL = H_ATIVO + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ATIVO + V_FP + V_SYNC + V_BP;

  // One extra bit over the coordinate width keeps x+size sums from wrapping.
  localparam int CW    = COORD_W + 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    H_VIS    = CW'(H_ATIVO);
  localparam logic [CW-1:0]    V_VIS    = CW'(V_ATIVO);
  localparam logic [CW-1:0]    HS_INI   = CW'(H_ATIVO + H_FP);
  localparam logic [CW-1:0]    HS_FIM   = CW'(H_ATIVO + H_FP + H_SYNC);
  localparam logic [CW-1:0]    VS_INI   = CW'(V_ATIVO + V_FP);
  localparam logic [CW-1:0]    VS_FIM   = CW'(V_ATIVO + V_FP + V_SYNC);
  localparam logic [CW-1:0]    P1_INI   = CW'(PAL1_X);
  localparam logic [CW-1:0]    P1_FIM   = CW'(PAL1_X + PAL_L);
  localparam logic [CW-1:0]    P2_INI   = CW'(PAL2_X);
  localparam logic [CW-1:0]    P2_FIM   = CW'(PAL2_X + PAL_L);
  localparam logic [CW-1:0]    BOLA_LADO = CW'(BOLA_T);
  localparam logic [CW-1:0]    BRD_BAIXO = CW'(BORDA);
  localparam logic [CW-1:0]    BRD_H_ALTO = CW'(H_ATIVO - BORDA);
  localparam logic [CW-1:0]    BRD_V_ALTO = CW'(V_ATIVO - BORDA);
  localparam logic [COR_W-1:0] COR_MAX  = {COR_W{1'b1}};

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [CW-1:0]      hc;
  logic [CW-1:0]      vc;
  logic               line_end;
  logic               frame_end;
  logic               boundary;

  logic [COORD_W-1:0] sh_p1_max;
  logic [COORD_W-1:0] sh_p1_min;
  logic [COORD_W-1:0] sh_p2_max;
  logic [COORD_W-1:0] sh_p2_min;
  logic [COORD_W-1:0] sh_bola_x;
  logic [COORD_W-1:0] sh_bola_y;
  logic               sh_bola_vis;

  logic [CW-1:0]      bola_x_ini;
  logic [CW-1:0]      bola_y_ini;
  logic [CW-1:0]      bola_x_fim;
  logic [CW-1:0]      bola_y_fim;

  logic               visible;
  logic               hsync_n;
  logic               vsync_n;
  logic               ball_hit;
  logic               pad1_hit;
  logic               pad2_hit;
  logic               border_hit;
  logic [COR_W-1:0]   r_next;
  logic [COR_W-1:0]   g_next;
  logic [COR_W-1:0]   b_next;

  // True when the raster position lies in a paddle column span and within
  // its inclusive vertical extent; an inverted extent matches no line.
  function automatic logic in_paddle(
    input logic [CW-1:0]      x,
    input logic [CW-1:0]      y,
    input logic [CW-1:0]      col_ini,
    input logic [CW-1:0]      col_fim,
    input logic [COORD_W-1:0] y_min,
    input logic [COORD_W-1:0] y_max
  );
    in_paddle = (x >= col_ini) && (x < col_fim) &&
                (y >= {1'b0, y_min}) && (y <= {1'b0, y_max});
  endfunction

  assign tick      = (div_cnt == DIV_LAST);
  assign line_end  = (hc == H_LAST);
  assign frame_end = line_end && (vc == V_LAST);
  assign boundary  = tick && frame_end;

  // Pixel-rate divider: tick fires on the last count of each DIV-clock period.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Raster counters: hc sweeps a line, vc advances when a line completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (tick) begin
      if (line_end) begin
        hc <= '0;
        if (vc == V_LAST) begin
          vc <= '0;
        end else begin
          vc <= vc + CW'(1);
        end
      end else begin
        hc <= hc + CW'(1);
      end
    end
  end

  // Position snapshot taken only at the frame boundary; reset hides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_p1_min   <= COORD_W'(1);
      sh_p1_max   <= '0;
      sh_p2_min   <= COORD_W'(1);
      sh_p2_max   <= '0;
      sh_bola_x   <= '0;
      sh_bola_y   <= '0;
      sh_bola_vis <= 1'b0;
    end else if (boundary) begin
      sh_p1_min   <= palete1YMinimo;
      sh_p1_max   <= palete1YMaximo;
      sh_p2_min   <= palete2YMinimo;
      sh_p2_max   <= palete2YMaximo;
      sh_bola_x   <= bolaX;
      sh_bola_y   <= bolaY;
      sh_bola_vis <= bolaVisivel;
    end
  end

  // Ball bounding box in widened arithmetic so x+size never wraps.
  always_comb begin
    bola_x_ini = {1'b0, sh_bola_x};
    bola_y_ini = {1'b0, sh_bola_y};
    bola_x_fim = bola_x_ini + BOLA_LADO;
    bola_y_fim = bola_y_ini + BOLA_LADO;
  end

  // Raster decode: sync windows, visible area and which scene objects cover hc/vc.
  always_comb begin
    visible    = (hc < H_VIS) && (vc < V_VIS);
    hsync_n    = !((hc >= HS_INI) && (hc < HS_FIM));
    vsync_n    = !((vc >= VS_INI) && (vc < VS_FIM));
    ball_hit   = sh_bola_vis &&
                 (hc >= bola_x_ini) && (hc < bola_x_fim) &&
                 (vc >= bola_y_ini) && (vc < bola_y_fim);
    pad1_hit   = in_paddle(hc, vc, P1_INI, P1_FIM, sh_p1_min, sh_p1_max);
    pad2_hit   = in_paddle(hc, vc, P2_INI, P2_FIM, sh_p2_min, sh_p2_max);
    border_hit = (BORDA > 0) &&
                 ((hc < BRD_BAIXO) || (hc >= BRD_H_ALTO) ||
                  (vc < BRD_BAIXO) || (vc >= BRD_V_ALTO));
  end

  // Colour priority: ball over paddles over border over black; blank outside.
  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (visible) begin
      if (ball_hit || pad1_hit || pad2_hit) begin
        r_next = COR_MAX;
        g_next = COR_MAX;
        b_next = COR_MAX;
      end else if (border_hit) begin
        g_next = COR_MAX;
      end
    end
  end

  // Video outputs registered on each pixel tick and held in between.
  always_ff @(posedge clock) begin
    if (reset) begin
      vermelho                <= '0;
      verde                   <= '0;
      azul                    <= '0;
      horizontalsincronizacao <= 1'b1;
      verticalsincronizacao   <= 1'b1;
      videoAtivo              <= 1'b0;
    end else if (tick) begin
      vermelho                <= r_next;
      verde                   <= g_next;
      azul                    <= b_next;
      horizontalsincronizacao <= hsync_n;
      verticalsincronizacao   <= vsync_n;
      videoAtivo              <= visible;
    end
  end

  // Frame pulse lasts exactly one clock, marking the snapshot instant.
  always_ff @(posedge clock) begin
    if (reset) begin
      fimQuadro <= 1'b0;
    end else begin
      fimQuadro <= boundary;
    end
  end

endmodule

// File: tb/tb_vga_pong_renderizador.sv
// tb_vga_pong_renderizador: self-checking bench for the pong renderer.
// Runs the design with a shrunken raster so several frames fit in a short
// run. Every clock is compared against a model that derives the raster
// position from elapsed clocks since reset; a table of hand-computed pixels
// and a few sequences cover snapshot timing, clipping and mid-frame reset.
module tb_vga_pong_renderizador;

  localparam int DIV = 2;
  localparam int HA  = 48;
  localparam int HFP = 2;
  localparam int HSW = 4;
  localparam int HBP = 2;
  localparam int VA  = 32;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int CW  = 11;
  localparam int COR = 4;
  localparam int P1X = 5;
  localparam int P2X = 36;
  localparam int PL  = 6;
  localparam int BT  = 4;
  localparam int BRD = 2;

  localparam int HT    = HA + HFP + HSW + HBP;
  localparam int VT    = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int CF    = DIV * FRAME;
  localparam int MAX_FAILS = 30;

  localparam logic [11:0] W = 12'hFFF;
  localparam logic [11:0] G = 12'h0F0;
  localparam logic [11:0] K = 12'h000;

  typedef struct {
    int p1min; int p1max; int p2min; int p2max; int bx; int by; bit vis;
  } geom_t;

  typedef struct {
    int grp; geom_t g; int h; int v; logic [11:0] rgb;
  } vec_t;

  logic          clock;
  logic          reset;
  logic [CW-1:0] p1_max, p1_min, p2_max, p2_min, ball_x, ball_y;
  logic          ball_vis;
  logic [COR-1:0] vermelho, verde, azul;
  logic          hsync, vsync, video_ativo, fim_quadro;

  int    m_cnt = 0;
  int    checks = 0;
  int    failures = 0;
  geom_t sh;
  geom_t grp_tab[4];
  vec_t  vecs[$];

  vga_pong_renderizador #(
    .DIV(DIV), .H_ATIVO(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ATIVO(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .COORD_W(CW), .COR_W(COR), .PAL1_X(P1X), .PAL2_X(P2X),
    .PAL_L(PL), .BOLA_T(BT), .BORDA(BRD)
  ) dut (
    .clock(clock), .reset(reset),
    .palete1YMaximo(p1_max), .palete1YMinimo(p1_min),
    .palete2YMaximo(p2_max), .palete2YMinimo(p2_min),
    .bolaX(ball_x), .bolaY(ball_y), .bolaVisivel(ball_vis),
    .vermelho(vermelho), .verde(verde), .azul(azul),
    .horizontalsincronizacao(hsync), .verticalsincronizacao(vsync),
    .videoAtivo(video_ativo), .fimQuadro(fim_quadro)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clocks elapsed since the last edge that sampled reset high.
  always @(posedge clock) begin
    if (reset) m_cnt <= 0;
    else       m_cnt <= m_cnt + 1;
  end

  function automatic geom_t hidden_geom();
    geom_t g;
    g.p1min = 1; g.p1max = 0; g.p2min = 1; g.p2max = 0;
    g.bx = 0; g.by = 0; g.vis = 1'b0;
    return g;
  endfunction

  function automatic geom_t mk_geom(int a, int b, int c, int d, int x, int y, bit vis);
    geom_t g;
    g.p1min = a; g.p1max = b; g.p2min = c; g.p2max = d;
    g.bx = x; g.by = y; g.vis = vis;
    return g;
  endfunction

  // Expected {rgb, hsync, vsync, videoAtivo, fimQuadro} after clock m of a run.
  function automatic logic [15:0] model(int m, geom_t s);
    int t, p, h, v;
    bit va, hs, vs, fim;
    logic [11:0] rgb;
    t = m / DIV;
    if (t == 0) return {12'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    p   = (t - 1) % FRAME;
    h   = p % HT;
    v   = p / HT;
    fim = (m % CF) == 0;
    va  = (h < HA) && (v < VA);
    hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    rgb = K;
    if (va) begin
      if (s.vis && h >= s.bx && h < s.bx + BT && v >= s.by && v < s.by + BT) rgb = W;
      else if (h >= P1X && h < P1X + PL && v >= s.p1min && v <= s.p1max)   rgb = W;
      else if (h >= P2X && h < P2X + PL && v >= s.p2min && v <= s.p2max)   rgb = W;
      else if (h < BRD || h >= HA - BRD || v < BRD || v >= VA - BRD)        rgb = G;
    end
    return {rgb, hs, vs, va, fim};
  endfunction

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      if (failures >= MAX_FAILS) finish_run();
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out at clock %0d", name, m_cnt);
    if (failures >= MAX_FAILS) finish_run();
  endtask

  // One clock: compare every output to the model, then track the snapshot.
  task automatic step();
    logic [15:0] act, exp;
    @(negedge clock);
    act = {vermelho, verde, azul, hsync, vsync, video_ativo, fim_quadro};
    exp = model(m_cnt, sh);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL stream m=%0d: actual=0x%0h required=0x%0h", m_cnt, act, exp);
      if (failures >= MAX_FAILS) finish_run();
    end
    if (m_cnt == 0) sh = hidden_geom();
    else if (m_cnt % CF == 0)
      sh = mk_geom(int'(p1_min), int'(p1_max), int'(p2_min), int'(p2_max),
                   int'(ball_x), int'(ball_y), ball_vis);
  endtask

  task automatic applyStimulus(input geom_t g);
    p1_min = CW'(g.p1min); p1_max = CW'(g.p1max);
    p2_min = CW'(g.p2min); p2_max = CW'(g.p2max);
    ball_x = CW'(g.bx);    ball_y = CW'(g.by);
    ball_vis = g.vis;
  endtask

  task automatic wait_until_m(input int target, input string name);
    int budget;
    budget = 3 * CF;
    while (m_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    if (m_cnt != target) note_timeout(name);
  endtask

  // First frame whose pixels use inputs driven now.
  function automatic int next_frame();
    return (m_cnt + CF) / CF;
  endfunction

  // Wait for pixel (h,v) in frame min_frame or later, then compare its colour.
  task automatic checkOutput(input string name, input int h, input int v, input int min_frame,
                             input logic [11:0] exp_rgb, output int used);
    int f, target;
    f = min_frame;
    target = DIV * (f * FRAME + v * HT + h + 1);
    while (target <= m_cnt) begin
      f++;
      target = DIV * (f * FRAME + v * HT + h + 1);
    end
    wait_until_m(target, name);
    check_val(name, {20'h0, vermelho, verde, azul}, {20'h0, exp_rgb});
    used = f;
  endtask

  function automatic vec_t mk(int grp, int h, int v, logic [11:0] rgb);
    vec_t r;
    r.grp = grp; r.g = grp_tab[grp]; r.h = h; r.v = v; r.rgb = rgb;
    return r;
  endfunction

  task automatic randomize_inputs();
    p1_min = CW'($urandom_range(0, 34));
    p1_max = CW'($urandom_range(0, 34));
    p2_min = CW'($urandom_range(0, 34));
    p2_max = CW'($urandom_range(0, 34));
    ball_x = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 2047)) : CW'($urandom_range(0, 52));
    ball_y = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 2047)) : CW'($urandom_range(0, 36));
    ball_vis = 1'($urandom_range(0, 1));
  endtask

  // Test sequence.
  initial begin
    int mf, fu, fu2, cur_g, tgt, n;
    int hs_low, vs_low, va_hi, fim_cnt, fim_first, fim_second;

    grp_tab[0] = mk_geom(10, 20, 1, 0, 20, 20, 1'b0);
    grp_tab[1] = mk_geom(25, 12, 0, 31, 46, 28, 1'b1);
    grp_tab[2] = mk_geom(1, 0, 8, 12, 38, 10, 1'b1);
    grp_tab[3] = mk_geom(0, 0, 1, 0, 48, 10, 1'b1);

    vecs.push_back(mk(0, 5, 9, K));   vecs.push_back(mk(0, 5, 10, W));
    vecs.push_back(mk(0, 0, 15, G));  vecs.push_back(mk(0, 4, 15, K));
    vecs.push_back(mk(0, 11, 15, K)); vecs.push_back(mk(0, 10, 20, W));
    vecs.push_back(mk(0, 20, 20, K)); vecs.push_back(mk(0, 5, 21, K));
    vecs.push_back(mk(1, 36, 0, W));  vecs.push_back(mk(1, 7, 12, K));
    vecs.push_back(mk(1, 0, 20, G));  vecs.push_back(mk(1, 7, 20, K));
    vecs.push_back(mk(1, 41, 20, W)); vecs.push_back(mk(1, 42, 20, K));
    vecs.push_back(mk(1, 47, 27, G)); vecs.push_back(mk(1, 46, 28, W));
    vecs.push_back(mk(1, 45, 29, K)); vecs.push_back(mk(1, 47, 29, W));
    vecs.push_back(mk(1, 47, 31, W));
    vecs.push_back(mk(2, 39, 8, W));  vecs.push_back(mk(2, 38, 10, W));
    vecs.push_back(mk(2, 42, 11, K)); vecs.push_back(mk(2, 37, 13, K));
    vecs.push_back(mk(2, 41, 13, W)); vecs.push_back(mk(2, 38, 14, K));
    vecs.push_back(mk(3, 5, 0, W));   vecs.push_back(mk(3, 5, 1, G));
    vecs.push_back(mk(3, 47, 10, G)); vecs.push_back(mk(3, 47, 11, G));
    vecs.push_back(mk(3, 48, 10, K));

    sh = hidden_geom();
    reset = 1'b1;
    applyStimulus(hidden_geom());
    repeat (3) step();

    check_val("reset_rgb", {20'h0, vermelho, verde, azul}, 32'h0);
    check_val("reset_hsync", {31'h0, hsync}, 32'h1);
    check_val("reset_vsync", {31'h0, vsync}, 32'h1);
    check_val("reset_video", {31'h0, video_ativo}, 32'h0);
    check_val("reset_fim", {31'h0, fim_quadro}, 32'h0);
    reset = 1'b0;

    // Two aligned frames: sync widths, visible area and frame pulse spacing.
    wait_until_m(next_frame() * CF, "align_sync");
    hs_low = 0; vs_low = 0; va_hi = 0; fim_cnt = 0; fim_first = 0; fim_second = 0;
    for (int i = 0; i < 2 * CF; i++) begin
      step();
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (video_ativo) va_hi++;
      if (fim_quadro) begin
        fim_cnt++;
        if (fim_cnt == 1) fim_first = m_cnt;
        if (fim_cnt == 2) fim_second = m_cnt;
      end
    end
    check_val("hsync_low_clocks", hs_low, 2 * VT * HSW * DIV);
    check_val("vsync_low_clocks", vs_low, 2 * VSW * HT * DIV);
    check_val("video_clocks", va_hi, 2 * HA * VA * DIV);
    check_val("fim_count", fim_cnt, 2);
    check_val("fim_period", fim_second - fim_first, CF);

    // Hand-computed pixel table, one snapshot per group.
    cur_g = -1;
    mf = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].grp != cur_g) begin
        applyStimulus(vecs[i].g);
        mf = next_frame();
        cur_g = vecs[i].grp;
      end
      checkOutput($sformatf("vec%0d(%0d,%0d)", i, vecs[i].h, vecs[i].v),
                  vecs[i].h, vecs[i].v, mf, vecs[i].rgb, fu);
      mf = fu;
    end

    // Mid-frame input change must wait for the next frame boundary.
    applyStimulus(grp_tab[0]);
    checkOutput("mid_before", 5, 18, next_frame(), W, fu);
    p1_max = CW'(25);
    checkOutput("mid_same_frame", 5, 22, fu, K, fu2);
    checkOutput("mid_next_frame", 5, 22, fu + 1, W, fu2);

    // Random positions changing at arbitrary times, checked by the model.
    tgt = m_cnt + CF;
    while (m_cnt < tgt) begin
      step();
      if ($urandom_range(0, 199) == 0) randomize_inputs();
    end

    // One-clock reset mid-frame, then the first frame pulse a full frame later.
    n = next_frame();
    wait_until_m(DIV * (n * FRAME + 20 * HT + 30 + 1), "align_reset");
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("midreset_rgb", {20'h0, vermelho, verde, azul}, 32'h0);
    check_val("midreset_syncs", {30'h0, hsync, vsync}, 32'h3);
    check_val("midreset_video_fim", {30'h0, video_ativo, fim_quadro}, 32'h0);
    n = 0;
    while (!fim_quadro && n < 2 * CF) begin
      step();
      n++;
    end
    check_val("fim_after_reset", m_cnt, CF);

    finish_run();
  end

endmodule
